uart_tx: RTL and testbench

UART transmit serializer. Consumes bytes from a valid/ready stream, normally the output of the team's elastic buffer, and drives the asynchronous serial line. Each frame is one start bit, DLEN data bits LSB-first, an optional parity bit, and one or two stop bits. It sits at the transmit edge of the UART, mirroring the receive path.

---
 rtl/uart_tx_if.sv | 15 +
 rtl/uart_tx.sv | 161 ++++++++++++++++
 tb/tb_uart_tx.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte stream handshake into the UART transmitter.
//   i_valid : producer has a byte available
//   i_data  : byte to send, sampled on the handshake edge
//   o_ready : transmitter can take a byte this cycle (registered)
// master = byte producer, slave = uart_tx.
interface uart_tx_if #(
  parameter int unsigned DLEN = 8
);
  logic            i_valid;
  logic            o_ready;
  logic [DLEN-1:0] i_data;

  modport master (output i_valid, output i_data, input o_ready);
  modport slave  (input i_valid, input i_data, output o_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmit serializer. Each frame is: one start bit, DLEN data bits
// sent LSB first, an optional parity bit, and STOP_BITS stop bits. Every
// bit lasts exactly CLKS_PER_BIT clock cycles.
//   clk    : sole clock, rising edge
//   rst    : asynchronous, active-high reset
//   s_if   : byte stream (i_valid / i_data in, registered o_ready out)
//   o_tx   : serial line, registered, idle/mark = 1
//   o_busy : registered, high while a frame is on the line
module uart_tx #(
  parameter int unsigned DLEN         = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  s_if,
  output logic      o_tx,
  output logic      o_busy
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W  = $clog2(DLEN) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DLEN - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic              PAR_ON    = (PARITY_EN != 0);
  localparam logic              PAR_INV   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              stop_q, stop_d;
  logic [DLEN-1:0]   shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              bit_end;
  logic              handshake;

  assign bit_end   = (baud_q == BAUD_LAST);
  assign handshake = s_if.i_valid & ready_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;

    // The baud counter runs in every frame state and restarts at each bit
    // boundary, so bit lengths never accumulate error.
    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (handshake) begin
          state_d = START;
          shift_d = s_if.i_data;
          par_d   = PAR_ON ? ((^s_if.i_data) ^ PAR_INV) : 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            state_d = PAR_ON ? PARITY : STOP;
            stop_d  = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so that the line,
  // ready and busy all change on the same edge as the state itself.
  always_comb begin
    tx_d    = 1'b1;
    ready_d = 1'b0;
    busy_d  = 1'b1;
    unique case (state_d)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign o_tx        = tx_q;
  assign o_busy      = busy_q;
  assign s_if.o_ready = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx. Three instances with CLKS_PER_BIT = 4:
//   dut 0 : 8N1, dut 1 : 8E1 (even parity), dut 2 : 8O2 (odd parity, 2 stops)
// A frame-level reference model predicts line, ready and busy every cycle;
// directed table entries and hand sequences check frame contents and timing.
module tb_uart_tx;
  localparam int unsigned C    = 4;
  localparam int unsigned NDUT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld    [NDUT];
  logic [7:0] din    [NDUT];
  logic       tx_w   [NDUT];
  logic       rdy_w  [NDUT];
  logic       busy_w [NDUT];

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    uart_tx_if #(.DLEN(8)) bus ();
    assign bus.i_valid = vld[g];
    assign bus.i_data  = din[g];
    assign rdy_w[g]    = bus.o_ready;
    uart_tx #(
      .DLEN(8),
      .CLKS_PER_BIT(C),
      .PARITY_EN((g != 0) ? 1 : 0),
      .PARITY_ODD((g == 2) ? 1 : 0),
      .STOP_BITS((g == 2) ? 2 : 1)
    ) dut (
      .clk(clk),
      .rst(rst),
      .s_if(bus),
      .o_tx(tx_w[g]),
      .o_busy(busy_w[g])
    );
  end

  function automatic logic cfg_pen(input int unsigned k);
    return k != 0;
  endfunction

  function automatic logic cfg_podd(input int unsigned k);
    return k == 2;
  endfunction

  function automatic int unsigned cfg_sb(input int unsigned k);
    return (k == 2) ? 2 : 1;
  endfunction

  function automatic int unsigned frame_len(input int unsigned k);
    return (1 + 8 + int'(cfg_pen(k)) + cfg_sb(k)) * C;
  endfunction

  // Frame as a list of bit values, index 0 = start bit; unused tail = mark.
  function automatic logic [15:0] frame_bits(input logic [7:0] d, input int unsigned k);
    logic [15:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    if (cfg_pen(k)) f[9] = (^d) ^ cfg_podd(k);
    return f;
  endfunction

  // Reference model: idle/ready flag plus elapsed cycles into the current frame.
  logic [15:0] m_fb  [NDUT];
  int unsigned m_el  [NDUT];
  logic        m_act [NDUT];
  logic        m_rdy [NDUT];

  always @(posedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (rst) begin
        m_act[k] <= 1'b0;
        m_rdy[k] <= 1'b0;
        m_el[k]  <= 0;
      end else if (m_rdy[k] && vld[k]) begin
        m_act[k] <= 1'b1;
        m_rdy[k] <= 1'b0;
        m_el[k]  <= 0;
        m_fb[k]  <= frame_bits(din[k], k);
      end else if (m_act[k]) begin
        if (m_el[k] + 1 == frame_len(k)) begin
          m_act[k] <= 1'b0;
          m_rdy[k] <= 1'b1;
        end
        m_el[k] <= m_el[k] + 1;
      end else begin
        m_rdy[k] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      logic [2:0] e;
      logic [2:0] a;
      if (rst) e = 3'b100;
      else e = {(m_act[k] ? m_fb[k][m_el[k] / C] : 1'b1), m_rdy[k], m_act[k]};
      a = {tx_w[k], rdy_w[k], busy_w[k]};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard dut%0d t=%0t tx/rdy/busy got %b expected %b", k, $time, a, e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Present one byte, wait (bounded) for its handshake, then record the line.
  task automatic send_frame(input int unsigned k, input logic [7:0] d,
                            output logic ok, output int unsigned len,
                            output logic [15:0] centers, output logic stable);
    logic s [0:199];
    ok      = 1'b0;
    len     = 0;
    centers = '1;
    stable  = 1'b1;
    vld[k]  = 1'b1;
    din[k]  = d;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (rdy_w[k]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vld[k] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    vld[k] = 1'b0;
    din[k] = ~d;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (!busy_w[k]) break;
      s[t] = tx_w[k];
      len++;
    end
    for (int i = 0; i < 16; i++) begin
      if (i * C + C <= len) begin
        centers[i] = s[i*C+1];
        for (int j = 1; j < C; j++) if (s[i*C+j] !== s[i*C]) stable = 1'b0;
      end
    end
  endtask

  typedef struct {
    int unsigned dut;
    logic [7:0]  data;
    int unsigned cycles;
    logic        par;
  } vec_t;

  task automatic run_vec(input vec_t v);
    logic        ok;
    int unsigned len;
    logic [15:0] cen;
    logic        st;
    int unsigned p;
    send_frame(v.dut, v.data, ok, len, cen, st);
    chk("handshake", ok, 1'b1);
    chk("frame_len", len, v.cycles);
    chk("start_bit", cen[0], 1'b0);
    chk("data_bits", cen[8:1], v.data);
    chk("bit_width", st, 1'b1);
    p = 9 + int'(cfg_pen(v.dut));
    if (cfg_pen(v.dut)) chk("parity_bit", cen[9], v.par);
    chk("stop_bit", cen[p], 1'b1);
  endtask

  initial begin
    vec_t        tbl [9];
    int unsigned cnt;
    int unsigned gap;
    logic        seen;

    tbl[0] = '{0, 8'hA5, 40, 1'b0};
    tbl[1] = '{1, 8'hA5, 44, 1'b0};
    tbl[2] = '{2, 8'hA5, 48, 1'b1};
    tbl[3] = '{1, 8'h01, 44, 1'b1};
    tbl[4] = '{1, 8'hF7, 44, 1'b1};
    tbl[5] = '{2, 8'h00, 48, 1'b1};
    tbl[6] = '{2, 8'hFF, 48, 1'b1};
    tbl[7] = '{2, 8'h01, 48, 1'b0};
    tbl[8] = '{0, 8'h5A, 40, 1'b0};

    for (int k = 0; k < NDUT; k++) begin
      vld[k] = 1'b0;
      din[k] = '0;
    end

    // Reset release: ready must wait for the first edge.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #2 chk("ready_before_edge", rdy_w[0], 1'b0);
    @(posedge clk);
    #1 chk("ready_after_edge", rdy_w[0], 1'b1);
    cnt = 0;
    repeat (100) @(negedge clk) if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) cnt++;
    chk("idle_mark_100", cnt, 0);

    // Asynchronous assertion mid-cycle.
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("async_rst_ready", rdy_w[0], 1'b0);
    chk("async_rst_tx", tx_w[0], 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // Reset during data bit 3 of 0x3C, then a clean 0x81 frame.
    vld[0] = 1'b1;
    din[0] = 8'h3C;
    seen = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (rdy_w[0]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("midrst_handshake", seen, 1'b1);
    @(posedge clk);
    #1 vld[0] = 1'b0;
    repeat (4 + 3 * C) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("midrst_tx", tx_w[0], 1'b1);
    chk("midrst_busy", busy_w[0], 1'b0);
    chk("midrst_ready", rdy_w[0], 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_vec('{0, 8'h81, 40, 1'b0});

    // Back-to-back on dut 2 with valid held and data changed mid-frame.
    vld[2] = 1'b1;
    din[2] = 8'h00;
    seen = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (busy_w[2]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("b2b_first_start", seen, 1'b1);
    din[2] = 8'hFF;
    cnt = 1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (!busy_w[2]) break;
      cnt++;
    end
    gap = 0;
    for (int t = 0; t < 100; t++) begin
      if (busy_w[2]) break;
      gap++;
      @(negedge clk);
    end
    chk("b2b_frame_cycles", cnt, 48);
    chk("b2b_mark_gap", gap, 1);
    chk("b2b_second_start", tx_w[2], 1'b0);
    vld[2] = 1'b0;
    repeat (60) @(posedge clk);

    // Random traffic with occasional reset pulses, checked by the model.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 399) == 0);
      for (int k = 0; k < NDUT; k++) begin
        vld[k] = ($urandom_range(0, 3) != 0);
        din[k] = 8'($urandom);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < NDUT; k++) vld[k] = 1'b0;
    repeat (60) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
